csi2_pkt_crc_check: RTL and testbench
=====================================

Name: csi2_pkt_crc_check

Overview:
- Long-packet payload checker placed directly downstream of the packet header parser.
- Counts payload bytes against the header word count and feeds them to an embedded `csi2_crc_calc` instance.
- Captures the 2-byte trailing checksum, compares it with the computed CRC, and reports pass/fail per packet.
- Forwards the payload bytes, registered, to the pixel unpacker.

Parameters:
- `WC_WIDTH`, 16, width of the word-count field from the packet header.
- `CRC_INIT`, 16'hFFFF, CRC seed loaded at each packet start.
- `ERR_CNT_WIDTH`, 16, width of the saturating CRC error counter (used only with the optional feature).

Ports:
- `clk_i`  in  1  byte clock.
- `rst_i`  in  1  reset; asynchronous, active-high.
- `pkt_start_i`  in  1  one-cycle pulse: a long-packet header was accepted; `wc_i` is valid in the same cycle.
- `wc_i`  in  `WC_WIDTH`  payload length in bytes.
- `valid_i`  in  1  `data_i` carries a payload or checksum byte.
- `data_i`  in  8  byte, in transmission order.
- `pld_valid_o`  out  1  registered payload byte valid.
- `pld_data_o`  out  8  registered payload byte.
- `pld_last_o`  out  1  marks the final payload byte.
- `crc_done_o`  out  1  one-cycle pulse: checksum compared.
- `crc_err_o`  out  1  qualified by `crc_done_o`; 1 means mismatch.
- `crc_rx_o`  out  16  received checksum, held until the next `crc_done_o`.
- `crc_calc_o`  out  16  computed CRC, held until the next `crc_done_o`.
- `busy_o`  out  1  FSM is not in IDLE.
- `err_cnt_o`  out  `ERR_CNT_WIDTH`  CRC error count (only with `CSI2_CRC_ERR_CNT_EN`).

Behaviour:
- Reset values: all outputs 0; FSM in IDLE; byte counter 0. The CRC instance is reset (its sync reset is driven from `rst_i`).
- CRC instance configuration: `POLY` 16'h1021, `CRC_SIZE` 16, `DATA_WIDTH` 8, `REF_IN` and `REF_OUT` "TRUE", `XOR_OUT` 0.
  - `init_i` = `CRC_INIT`.
  - `soft_reset_i` = `pkt_start_i`.
  - `valid_i` = `valid_i` AND state==PAYLOAD.
- FSM states:
  - IDLE: on `pkt_start_i`, load `cnt` = `wc_i`. Go to PAYLOAD if `wc_i` != 0, else to CRC_LSB. `valid_i` in IDLE is ignored.
  - PAYLOAD: each accepted byte decrements `cnt` and is forwarded one cycle later on `pld_*`. The byte with `cnt`==1 sets `pld_last_o`, and the FSM goes to CRC_LSB.
  - CRC_LSB: on `valid_i`, store `data_i` in `crc_rx[7:0]`; go to CRC_MSB.
  - CRC_MSB: on `valid_i`, form `crc_rx` = {`data_i`, lsb}.
    - Next cycle: `crc_done_o`=1, `crc_err_o` = (`crc_rx` != `crc_o` of the instance); `crc_rx_o` and `crc_calc_o` update.
    - FSM goes to IDLE.
- Latency:
  - `pld_*` lag `data_i` by 1 cycle.
  - `crc_done_o` rises 1 cycle after the MSB checksum byte.
  - The CRC register is already final because the last payload byte precedes the checksum by at least 1 cycle.
- Gaps: `valid_i`=0 stalls any state without side effects.
- Zero-length payload (WC=0): no `pld_*` activity; expected CRC = `CRC_INIT` (16'hFFFF).
- `pkt_start_i` while `busy_o`: abort the current packet.
  - No `crc_done_o` and no `pld_last_o` for it.
  - Restart with the new `wc_i` (the CRC is re-seeded in the same cycle).
  - A byte with `valid_i` in that same cycle is dropped.
- `pkt_start_i` in the same cycle as `crc_done_o` is legal: the done pulse is issued and the new packet starts.
- The 16-bit counter handles WC up to 65535 with no wrap; it never decrements below 0.
- Asynchronous reset mid-packet: immediate return to IDLE with all outputs cleared. `crc_rx_o`, `crc_calc_o` and `err_cnt_o` clear too.

Optional Feature:
- Macro: `CSI2_CRC_ERR_CNT_EN`.
- Defined: `err_cnt_o` increments on each `crc_done_o` with `crc_err_o`=1, and saturates at all-ones. It is cleared only by `rst_i`.
- Undefined: `err_cnt_o` is tied to 0 and no counter is synthesised.

Decomposition:
- Shared package `csi2_pkg`:
  - FSM state enum `crc_chk_state_t` (IDLE, PAYLOAD, CRC_LSB, CRC_MSB).
  - Constants `CSI2_CRC_POLY` = 16'h1021 and `CSI2_CRC_INIT` = 16'hFFFF.
- One sub-module: the existing `csi2_crc_calc`, instantiated once. No other sub-modules.

Test Plan:
- WC=9, payload ASCII "123456789" (0x31..0x39), then checksum bytes 0x91 0x6F → `pld_last_o` on byte 9; `crc_done_o` with `crc_err_o`=0; `crc_calc_o`=16'h6F91.
- Same packet with checksum bytes 0x92 0x6F → `crc_err_o`=1, `crc_rx_o`=16'h6F92; `err_cnt_o`=1 when `CSI2_CRC_ERR_CNT_EN` is defined, otherwise 0.
- WC=0, then checksum bytes 0xFF 0xFF → no `pld_valid_o`; `crc_err_o`=0, `crc_calc_o`=16'hFFFF.
- WC=9 with random `valid_i` gaps (about 50% duty) → identical results to the first scenario; `pld_data_o` matches the input order.
- `pkt_start_i` (WC=4) after 5 bytes of a WC=9 packet, then 4 bytes plus a correct checksum → exactly one `crc_done_o`, no error; `pld_last_o` only on the 4th byte of the new packet.
- Assert `rst_i` asynchronously while in CRC_MSB → outputs 0 and `busy_o`=0 immediately; the next packet checks correctly.

Source files
------------

// File: rtl/csi2_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : csi2_pkg                                                          |
// | Brief  : Shared CSI-2 types and constants for the payload CRC checker.     |
// | Rev    : 1.0                                                               |
// +----------------------------------------------------------------------------+
package csi2_pkg;

    localparam logic [15:0] CSI2_CRC_POLY = 16'h1021;
    localparam logic [15:0] CSI2_CRC_INIT = 16'hFFFF;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PAYLOAD = 2'd1,
        CRC_LSB = 2'd2,
        CRC_MSB = 2'd3
    } crc_chk_state_t;

endpackage
`default_nettype wire

// File: rtl/csi2_crc_calc.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : csi2_crc_calc                                                     |
// | Brief  : Parameterised byte-parallel CRC with optional in/out reflection.  |
// | Rev    : 1.0                                                               |
// +----------------------------------------------------------------------------+
module csi2_crc_calc #(
    parameter int                  CRC_SIZE   = 16,
    parameter logic [CRC_SIZE-1:0] POLY       = 16'h1021,
    parameter int                  DATA_WIDTH = 8,
    parameter                      REF_IN     = "TRUE",
    parameter                      REF_OUT    = "TRUE",
    parameter logic [CRC_SIZE-1:0] XOR_OUT    = '0
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [CRC_SIZE-1:0]   init_i,
    input  logic                  soft_reset_i,
    input  logic                  valid_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    output logic [CRC_SIZE-1:0]   crc_o
);

    logic [DATA_WIDTH-1:0] data_w;
    logic [CRC_SIZE-1:0]   crc_q;
    logic [CRC_SIZE-1:0]   crc_d;
    logic [CRC_SIZE-1:0]   crc_out_w;

    // The register always runs MSB-first; reflection is applied at the edges.
    if (REF_IN == "TRUE") begin : g_ref_in
        for (genvar i = 0; i < DATA_WIDTH; i++) begin : g_bit
            assign data_w[i] = data_i[DATA_WIDTH-1-i];
        end
    end else begin : g_no_ref_in
        assign data_w = data_i;
    end

    if (REF_OUT == "TRUE") begin : g_ref_out
        for (genvar i = 0; i < CRC_SIZE; i++) begin : g_bit
            assign crc_out_w[i] = crc_q[CRC_SIZE-1-i];
        end
    end else begin : g_no_ref_out
        assign crc_out_w = crc_q;
    end

    assign crc_o = crc_out_w ^ XOR_OUT;

    always_comb begin
        logic fb;
        fb    = 1'b0;
        crc_d = crc_q;
        for (int i = DATA_WIDTH - 1; i >= 0; i--) begin
            fb    = crc_d[CRC_SIZE-1] ^ data_w[i];
            crc_d = {crc_d[CRC_SIZE-2:0], 1'b0} ^ (fb ? POLY : '0);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            crc_q <= init_i;
        end else if (soft_reset_i) begin
            crc_q <= init_i;
        end else if (valid_i) begin
            crc_q <= crc_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/csi2_pkt_crc_check.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : csi2_pkt_crc_check                                                |
// | Brief  : Long-packet payload counter, forwarder and checksum checker.      |
// |          Define CSI2_CRC_ERR_CNT_EN for the saturating CRC error counter.  |
// | Rev    : 1.0                                                               |
// +----------------------------------------------------------------------------+
module csi2_pkt_crc_check
    import csi2_pkg::*;
#(
    parameter int           WC_WIDTH      = 16,
    parameter logic [15:0]  CRC_INIT      = CSI2_CRC_INIT,
    parameter int           ERR_CNT_WIDTH = 16
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     pkt_start_i,
    input  logic [WC_WIDTH-1:0]      wc_i,
    input  logic                     valid_i,
    input  logic [7:0]               data_i,
    output logic                     pld_valid_o,
    output logic [7:0]               pld_data_o,
    output logic                     pld_last_o,
    output logic                     crc_done_o,
    output logic                     crc_err_o,
    output logic [15:0]              crc_rx_o,
    output logic [15:0]              crc_calc_o,
    output logic                     busy_o,
    output logic [ERR_CNT_WIDTH-1:0] err_cnt_o
);

    crc_chk_state_t      state_q, state_d;
    logic [WC_WIDTH-1:0] cnt_q, cnt_d;
    logic [7:0]          lsb_q, lsb_d;
    logic                pld_valid_q, pld_valid_d;
    logic [7:0]          pld_data_q, pld_data_d;
    logic                pld_last_q, pld_last_d;
    logic                crc_done_q, crc_done_d;
    logic                crc_err_q, crc_err_d;
    logic [15:0]         crc_rx_q, crc_rx_d;
    logic [15:0]         crc_calc_q, crc_calc_d;
    logic [15:0]         crc_w;
    logic                crc_valid_w;

    assign crc_valid_w = valid_i && (state_q == PAYLOAD);

    // Soft reset outranks valid in the instance, so an aborting byte is dropped.
    csi2_crc_calc #(
        .CRC_SIZE   (16),
        .POLY       (CSI2_CRC_POLY),
        .DATA_WIDTH (8),
        .REF_IN     ("TRUE"),
        .REF_OUT    ("TRUE"),
        .XOR_OUT    (16'h0000)
    ) u_crc (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .init_i       (CRC_INIT),
        .soft_reset_i (pkt_start_i),
        .valid_i      (crc_valid_w),
        .data_i       (data_i),
        .crc_o        (crc_w)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        lsb_d       = lsb_q;
        pld_valid_d = 1'b0;
        pld_data_d  = pld_data_q;
        pld_last_d  = 1'b0;
        crc_done_d  = 1'b0;
        crc_err_d   = crc_err_q;
        crc_rx_d    = crc_rx_q;
        crc_calc_d  = crc_calc_q;

        if (pkt_start_i) begin
            cnt_d   = wc_i;
            state_d = (wc_i != '0) ? PAYLOAD : CRC_LSB;
        end else if (valid_i) begin
            case (state_q)
                PAYLOAD: begin
                    pld_valid_d = 1'b1;
                    pld_data_d  = data_i;
                    pld_last_d  = (cnt_q == WC_WIDTH'(1));
                    if (cnt_q != '0) begin
                        cnt_d = cnt_q - WC_WIDTH'(1);
                    end
                    if (cnt_q <= WC_WIDTH'(1)) begin
                        state_d = CRC_LSB;
                    end
                end
                CRC_LSB: begin
                    lsb_d   = data_i;
                    state_d = CRC_MSB;
                end
                CRC_MSB: begin
                    crc_rx_d   = {data_i, lsb_q};
                    crc_calc_d = crc_w;
                    crc_done_d = 1'b1;
                    crc_err_d  = ({data_i, lsb_q} != crc_w);
                    state_d    = IDLE;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            lsb_q       <= '0;
            pld_valid_q <= 1'b0;
            pld_data_q  <= '0;
            pld_last_q  <= 1'b0;
            crc_done_q  <= 1'b0;
            crc_err_q   <= 1'b0;
            crc_rx_q    <= '0;
            crc_calc_q  <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            lsb_q       <= lsb_d;
            pld_valid_q <= pld_valid_d;
            pld_data_q  <= pld_data_d;
            pld_last_q  <= pld_last_d;
            crc_done_q  <= crc_done_d;
            crc_err_q   <= crc_err_d;
            crc_rx_q    <= crc_rx_d;
            crc_calc_q  <= crc_calc_d;
        end
    end

`ifdef CSI2_CRC_ERR_CNT_EN
    logic [ERR_CNT_WIDTH-1:0] err_cnt_q, err_cnt_d;

    // Updates on the same edge as the done pulse, so it is current alongside it.
    always_comb begin
        err_cnt_d = err_cnt_q;
        if (crc_done_d && crc_err_d && (err_cnt_q != '1)) begin
            err_cnt_d = err_cnt_q + ERR_CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            err_cnt_q <= '0;
        end else begin
            err_cnt_q <= err_cnt_d;
        end
    end

    assign err_cnt_o = err_cnt_q;
`else
    assign err_cnt_o = '0;
`endif

    assign pld_valid_o = pld_valid_q;
    assign pld_data_o  = pld_data_q;
    assign pld_last_o  = pld_last_q;
    assign crc_done_o  = crc_done_q;
    assign crc_err_o   = crc_err_q;
    assign crc_rx_o    = crc_rx_q;
    assign crc_calc_o  = crc_calc_q;
    assign busy_o      = (state_q != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_csi2_pkt_crc_check.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : tb_csi2_pkt_crc_check                                             |
// | Brief  : Directed self-checking bench for csi2_pkt_crc_check.              |
// | Rev    : 1.0                                                               |
// +----------------------------------------------------------------------------+
module tb_csi2_pkt_crc_check;

    typedef logic [7:0] bytes_t[$];

`ifdef CSI2_CRC_ERR_CNT_EN
    localparam logic [15:0] c_exp_err_cnt = 16'd1;
`else
    localparam logic [15:0] c_exp_err_cnt = 16'd0;
`endif

    logic        clk_i       = 1'b0;
    logic        rst_i       = 1'b1;
    logic        pkt_start_i = 1'b0;
    logic [15:0] wc_i        = '0;
    logic        valid_i     = 1'b0;
    logic [7:0]  data_i      = '0;
    logic        pld_valid_o;
    logic [7:0]  pld_data_o;
    logic        pld_last_o;
    logic        crc_done_o;
    logic        crc_err_o;
    logic [15:0] crc_rx_o;
    logic [15:0] crc_calc_o;
    logic        busy_o;
    logic [15:0] err_cnt_o;

    always #5 clk_i = ~clk_i;

    csi2_pkt_crc_check u_dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .pkt_start_i (pkt_start_i),
        .wc_i        (wc_i),
        .valid_i     (valid_i),
        .data_i      (data_i),
        .pld_valid_o (pld_valid_o),
        .pld_data_o  (pld_data_o),
        .pld_last_o  (pld_last_o),
        .crc_done_o  (crc_done_o),
        .crc_err_o   (crc_err_o),
        .crc_rx_o    (crc_rx_o),
        .crc_calc_o  (crc_calc_o),
        .busy_o      (busy_o),
        .err_cnt_o   (err_cnt_o)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check_value(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    logic [7:0]  mon_pld[$];
    int          mon_last[$];
    int          mon_done = 0;
    logic        mon_err  = 1'b0;
    logic [15:0] mon_rx   = '0;
    logic [15:0] mon_calc = '0;

    always @(negedge clk_i) begin
        if (pld_valid_o) begin
            mon_pld.push_back(pld_data_o);
            if (pld_last_o) mon_last.push_back(mon_pld.size() - 1);
        end
        if (crc_done_o) begin
            mon_done++;
            mon_err  = crc_err_o;
            mon_rx   = crc_rx_o;
            mon_calc = crc_calc_o;
        end
    end

    // Reflected CRC-16 (0x8408 right-shift form), independent of the DUT's structure.
    function automatic logic [15:0] crc_ref(input bytes_t p);
        logic [15:0] c;
        c = 16'hFFFF;
        foreach (p[i]) begin
            c = c ^ {8'h00, p[i]};
            for (int b = 0; b < 8; b++) begin
                c = c[0] ? ((c >> 1) ^ 16'h8408) : (c >> 1);
            end
        end
        return c;
    endfunction

    task automatic drive(input logic v, input logic [7:0] d, input logic st, input logic [15:0] wc);
        @(negedge clk_i);
        valid_i     = v;
        data_i      = d;
        pkt_start_i = st;
        wc_i        = wc;
    endtask

    task automatic send_bytes(input bytes_t b, input bit gaps);
        foreach (b[i]) begin
            if (gaps) repeat ($urandom_range(0, 2)) drive(1'b0, 8'h00, 1'b0, 16'h0);
            drive(1'b1, b[i], 1'b0, 16'h0);
        end
    endtask

    task automatic send_pkt(input logic [15:0] wc, input bytes_t p, input logic [7:0] c0,
                            input logic [7:0] c1, input bit gaps);
        bytes_t ck;
        ck = {c0, c1};
        drive(1'b0, 8'h00, 1'b1, wc);
        send_bytes(p, gaps);
        send_bytes(ck, gaps);
        repeat (3) drive(1'b0, 8'h00, 1'b0, 16'h0);
    endtask

    task automatic check_pkt(input string tag, input int p0, input int l0, input int d0,
                             input bytes_t exp, input logic err, input logic [15:0] rx,
                             input logic [15:0] calc);
        logic [31:0] act;
        check_value({tag, ".pld_n"}, mon_pld.size() - p0, exp.size());
        foreach (exp[i]) begin
            act = (p0 + i < mon_pld.size()) ? {24'h0, mon_pld[p0+i]} : 32'hDEAD;
            check_value($sformatf("%s.byte%0d", tag, i), act, {24'h0, exp[i]});
        end
        check_value({tag, ".last_n"}, mon_last.size() - l0, (exp.size() > 0) ? 1 : 0);
        if (exp.size() > 0 && mon_last.size() > l0)
            check_value({tag, ".last_pos"}, mon_last[l0], p0 + exp.size() - 1);
        check_value({tag, ".done_n"}, mon_done - d0, 1);
        check_value({tag, ".err"}, {31'h0, mon_err}, {31'h0, err});
        check_value({tag, ".rx"}, {16'h0, mon_rx}, {16'h0, rx});
        check_value({tag, ".calc"}, {16'h0, mon_calc}, {16'h0, calc});
    endtask

    initial begin
        bytes_t s9, none, a5, b4, ab, two;
        logic [15:0] c4;
        int p0, l0, d0;
        s9   = {8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
        none = {};
        a5   = {8'h31, 8'h32, 8'h33, 8'h34, 8'h35};
        b4   = {8'h41, 8'h42, 8'h43, 8'h44};
        ab   = {8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h41, 8'h42, 8'h43, 8'h44};
        two  = {8'h10, 8'h20};

        repeat (3) @(negedge clk_i);
        rst_i = 1'b0;
        @(negedge clk_i);
        check_value("rst.pld_valid", {31'h0, pld_valid_o}, 0);
        check_value("rst.done", {31'h0, crc_done_o}, 0);
        check_value("rst.busy", {31'h0, busy_o}, 0);
        check_value("rst.calc", {16'h0, crc_calc_o}, 0);
        check_value("rst.err_cnt", {16'h0, err_cnt_o}, 0);

        p0 = mon_pld.size(); l0 = mon_last.size(); d0 = mon_done;
        send_pkt(16'd9, s9, 8'h91, 8'h6F, 1'b0);
        check_pkt("good", p0, l0, d0, s9, 1'b0, 16'h6F91, 16'h6F91);

        p0 = mon_pld.size(); l0 = mon_last.size(); d0 = mon_done;
        send_pkt(16'd9, s9, 8'h92, 8'h6F, 1'b0);
        check_pkt("bad", p0, l0, d0, s9, 1'b1, 16'h6F92, 16'h6F91);
        check_value("bad.err_cnt", {16'h0, err_cnt_o}, {16'h0, c_exp_err_cnt});

        p0 = mon_pld.size(); l0 = mon_last.size(); d0 = mon_done;
        send_pkt(16'd0, none, 8'hFF, 8'hFF, 1'b0);
        check_pkt("wc0", p0, l0, d0, none, 1'b0, 16'hFFFF, 16'hFFFF);

        p0 = mon_pld.size(); l0 = mon_last.size(); d0 = mon_done;
        send_pkt(16'd9, s9, 8'h91, 8'h6F, 1'b1);
        check_pkt("gaps", p0, l0, d0, s9, 1'b0, 16'h6F91, 16'h6F91);

        // Abort a WC=9 packet after 5 bytes; the byte alongside the restart is dropped.
        c4 = crc_ref(b4);
        p0 = mon_pld.size(); l0 = mon_last.size(); d0 = mon_done;
        drive(1'b0, 8'h00, 1'b1, 16'd9);
        send_bytes(a5, 1'b0);
        drive(1'b1, 8'hAA, 1'b1, 16'd4);
        send_pkt_tail: begin
            bytes_t ck;
            ck = {c4[7:0], c4[15:8]};
            send_bytes(b4, 1'b0);
            send_bytes(ck, 1'b0);
            repeat (3) drive(1'b0, 8'h00, 1'b0, 16'h0);
        end
        check_pkt("abort", p0, l0, d0, ab, 1'b0, c4, c4);

        // Async reset while waiting for the checksum MSB.
        drive(1'b0, 8'h00, 1'b1, 16'd2);
        send_bytes(two, 1'b0);
        drive(1'b1, 8'h55, 1'b0, 16'h0);
        drive(1'b0, 8'h00, 1'b0, 16'h0);
        check_value("pre_rst.busy", {31'h0, busy_o}, 1);
        #2 rst_i = 1'b1;
        #1;
        check_value("arst.busy", {31'h0, busy_o}, 0);
        check_value("arst.rx", {16'h0, crc_rx_o}, 0);
        check_value("arst.calc", {16'h0, crc_calc_o}, 0);
        check_value("arst.err_cnt", {16'h0, err_cnt_o}, 0);
        check_value("arst.pld", {30'h0, pld_valid_o, pld_last_o}, 0);
        #10 rst_i = 1'b0;

        p0 = mon_pld.size(); l0 = mon_last.size(); d0 = mon_done;
        send_pkt(16'd9, s9, 8'h91, 8'h6F, 1'b0);
        check_pkt("post_rst", p0, l0, d0, s9, 1'b0, 16'h6F91, 16'h6F91);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
